bmem_arbiter: RTL and testbench

Two-port arbiter that shares the single burst-memory (bmem) channel between the out-of-order core's memory side and the pipelined core's memory side. It sits between the two cache/memory front ends and the FPGA memory controller. It grants one whole transaction at a time (one read request plus its data beats, or one full write burst) using round-robin priority. Responses are routed back only to the granted requester.

---
 rtl/bmem_arb_pkg.sv | 19 +
 rtl/bmem_rr_pick.sv | 22 ++
 rtl/bmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_bmem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_arb_pkg.sv
// Shared types for the bmem channel arbiter: FSM states, requester ids and
// the default burst length.
package bmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_BURST = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_OOO = 1'b0,
        REQ_PPL = 1'b1
    } req_id_e;

    localparam int unsigned BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/bmem_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not win last
// time is chosen.
module bmem_rr_pick
    import bmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_gnt,
    output logic       valid,
    output req_id_e    gnt
);

    always_comb begin
        valid = |req;
        gnt   = REQ_OOO;
        case (req)
            2'b10:   gnt = REQ_PPL;
            2'b11:   gnt = (last_gnt == REQ_OOO) ? REQ_PPL : REQ_OOO;
            default: gnt = REQ_OOO;
        endcase
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one bmem channel between the OoO and pipelined cores, granting a
// whole read (request + beats) or write burst at a time, round-robin.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ooo_bmem_addr,
    input  logic              ooo_bmem_read,
    input  logic              ooo_bmem_write,
    input  logic [63:0]       ooo_bmem_wdata,
    output logic              ooo_bmem_ready,
    output logic [ADDR_W-1:0] ooo_bmem_raddr,
    output logic [63:0]       ooo_bmem_rdata,
    output logic              ooo_bmem_rvalid,

    input  logic [ADDR_W-1:0] ppl_bmem_addr,
    input  logic              ppl_bmem_read,
    input  logic              ppl_bmem_write,
    input  logic [63:0]       ppl_bmem_wdata,
    output logic              ppl_bmem_ready,
    output logic [ADDR_W-1:0] ppl_bmem_raddr,
    output logic [63:0]       ppl_bmem_rdata,
    output logic              ppl_bmem_rvalid,

    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [63:0]       bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [63:0]       bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int unsigned     CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_e       state_q, state_d;
    req_id_e          gnt_q, gnt_d;
    req_id_e          last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [1:0] req;
    logic       pick_valid;
    req_id_e    pick_gnt;
    logic       pick_write;

    assign req        = {ppl_bmem_read | ppl_bmem_write, ooo_bmem_read | ooo_bmem_write};
    assign pick_write = (pick_gnt == REQ_PPL) ? ppl_bmem_write : ooo_bmem_write;

    bmem_rr_pick u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .valid    (pick_valid),
        .gnt      (pick_gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick_gnt;
                    last_gnt_d = pick_gnt;
                    beat_cnt_d = '0;
                    // write takes precedence if a requester raises both
                    state_d    = pick_write ? WR_BURST : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (bmem_ready) begin
                    state_d    = RD_WAIT;
                    beat_cnt_d = '0;
                end
            end
            RD_WAIT: begin
                if (bmem_rvalid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= REQ_OOO;
            last_gnt_q <= REQ_PPL;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    logic is_rd, is_wr, is_rwait, gnt_ppl, fwd_ready;

    assign is_rd     = (state_q == RD_ISSUE);
    assign is_wr     = (state_q == WR_BURST);
    assign is_rwait  = (state_q == RD_WAIT);
    assign gnt_ppl   = (gnt_q == REQ_PPL);
    assign fwd_ready = (is_rd | is_wr) & bmem_ready;

    // Everything is gated to zero outside the owning state so idle/ungranted
    // sides never see stray strobes or data.
    always_comb begin
        bmem_read       = is_rd;
        bmem_write      = is_wr;
        bmem_addr       = '0;
        bmem_wdata      = '0;
        if (is_rd | is_wr) begin
            bmem_addr = gnt_ppl ? ppl_bmem_addr : ooo_bmem_addr;
        end
        if (is_wr) begin
            bmem_wdata = gnt_ppl ? ppl_bmem_wdata : ooo_bmem_wdata;
        end

        ooo_bmem_ready  = fwd_ready & ~gnt_ppl;
        ppl_bmem_ready  = fwd_ready &  gnt_ppl;

        ooo_bmem_rvalid = is_rwait & ~gnt_ppl & bmem_rvalid;
        ppl_bmem_rvalid = is_rwait &  gnt_ppl & bmem_rvalid;
        ooo_bmem_rdata  = '0;
        ooo_bmem_raddr  = '0;
        ppl_bmem_rdata  = '0;
        ppl_bmem_raddr  = '0;
        if (is_rwait & ~gnt_ppl) begin
            ooo_bmem_rdata = bmem_rdata;
            ooo_bmem_raddr = bmem_raddr;
        end
        if (is_rwait & gnt_ppl) begin
            ppl_bmem_rdata = bmem_rdata;
            ppl_bmem_raddr = bmem_raddr;
        end
    end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Scoreboard bench for bmem_arbiter: requester agents push expected downstream
// traffic and read beats; a negedge monitor pops and compares them.
module tb_bmem_arbiter;

    localparam int unsigned BL = 4;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } down_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } rbeat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]         rq_read, rq_write, rq_ready, rq_rvalid;
    logic [1:0][AW-1:0] rq_addr, rq_raddr;
    logic [1:0][63:0]   rq_wdata, rq_rdata;

    logic          bmem_ready, ctl_rvalid, stray_rv;
    logic [AW-1:0] ctl_raddr;
    logic [63:0]   ctl_rdata, stray_rdata;
    logic [AW-1:0] bmem_addr;
    logic          bmem_read, bmem_write;
    logic [63:0]   bmem_wdata;

    bmem_arbiter #(.BURST_LEN(BL), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ooo_bmem_addr   (rq_addr[0]),
        .ooo_bmem_read   (rq_read[0]),
        .ooo_bmem_write  (rq_write[0]),
        .ooo_bmem_wdata  (rq_wdata[0]),
        .ooo_bmem_ready  (rq_ready[0]),
        .ooo_bmem_raddr  (rq_raddr[0]),
        .ooo_bmem_rdata  (rq_rdata[0]),
        .ooo_bmem_rvalid (rq_rvalid[0]),
        .ppl_bmem_addr   (rq_addr[1]),
        .ppl_bmem_read   (rq_read[1]),
        .ppl_bmem_write  (rq_write[1]),
        .ppl_bmem_wdata  (rq_wdata[1]),
        .ppl_bmem_ready  (rq_ready[1]),
        .ppl_bmem_raddr  (rq_raddr[1]),
        .ppl_bmem_rdata  (rq_rdata[1]),
        .ppl_bmem_rvalid (rq_rvalid[1]),
        .bmem_addr       (bmem_addr),
        .bmem_read       (bmem_read),
        .bmem_write      (bmem_write),
        .bmem_wdata      (bmem_wdata),
        .bmem_ready      (bmem_ready),
        .bmem_raddr      (ctl_raddr),
        .bmem_rdata      (stray_rv ? stray_rdata : ctl_rdata),
        .bmem_rvalid     (ctl_rvalid | stray_rv)
    );

    down_t         exp_down[2][$];
    rbeat_t        exp_rd[2][$];
    int            exp_gnt[$];
    logic [AW-1:0] rsp_q[$];
    logic          rdy_pat[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc      = 0;
    int          start_cyc[2];
    int          last_rv_cyc[2];
    bit          abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rd_beat(input logic [AW-1:0] a, input int unsigned b);
        return {a, 32'h0000_00A0 + b};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_bmem_read"},  64'(bmem_read),    64'd0);
        check({tag, "_bmem_write"}, 64'(bmem_write),   64'd0);
        check({tag, "_bmem_addr"},  64'(bmem_addr),    64'd0);
        check({tag, "_bmem_wdata"}, bmem_wdata,        64'd0);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_rq_ready"},  64'(rq_ready[i]),  64'd0);
            check({tag, "_rq_rvalid"}, 64'(rq_rvalid[i]), 64'd0);
            check({tag, "_rq_rdata"},  rq_rdata[i],       64'd0);
            check({tag, "_rq_raddr"},  64'(rq_raddr[i]),  64'd0);
        end
    endtask

    task automatic wait_ready(input int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (abort) return;
            if (rq_ready[id]) begin
                ok = 1'b1;
                return;
            end
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic req_read(input int id, input logic [AW-1:0] a);
        down_t  e;
        rbeat_t r;
        bit     ok;
        e.wr = 1'b0; e.addr = a; e.data = '0;
        exp_down[id].push_back(e);
        for (int unsigned b = 0; b < BL; b++) begin
            r.addr = a; r.data = rd_beat(a, b);
            exp_rd[id].push_back(r);
        end
        rq_addr[id] = a;
        rq_read[id] = 1'b1;
        wait_ready(id, ok);
        if (ok) begin
            @(posedge clk); #1;
        end
        rq_read[id] = 1'b0;
    endtask

    task automatic req_write(input int id, input logic [AW-1:0] a, input logic [63:0] d0);
        down_t e;
        bit    ok;
        for (int unsigned b = 0; b < BL; b++) begin
            e.wr = 1'b1; e.addr = a; e.data = d0 + 64'(b);
            exp_down[id].push_back(e);
        end
        rq_addr[id]  = a;
        rq_wdata[id] = d0;
        rq_write[id] = 1'b1;
        for (int unsigned b = 0; b < BL; b++) begin
            wait_ready(id, ok);
            if (!ok) begin
                rq_write[id] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            rq_wdata[id] = d0 + 64'(b + 1);
        end
        rq_write[id] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_down[0].size() == 0 && exp_down[1].size() == 0 &&
                exp_rd[0].size() == 0 && exp_rd[1].size() == 0 &&
                exp_gnt.size() == 0 && rq_read == 2'b00 && rq_write == 2'b00) begin
                @(posedge clk); #1;
                return;
            end
        end
        check({tag, "_drain_timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    // Controller model: ready from a pattern (default 1), four read beats
    // starting the cycle after each accepted read request.
    initial begin
        logic [AW-1:0] rsp_addr;
        int unsigned   rsp_beat;
        bit            rsp_active;
        rsp_active = 1'b0; rsp_beat = 0; rsp_addr = '0;
        bmem_ready = 1'b1; ctl_rvalid = 1'b0; ctl_raddr = '0; ctl_rdata = '0;
        forever begin
            @(posedge clk); #2;
            bmem_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
            ctl_rvalid = 1'b0;
            if (!rsp_active && rsp_q.size() != 0) begin
                rsp_addr   = rsp_q.pop_front();
                rsp_beat   = 0;
                rsp_active = 1'b1;
            end
            if (rsp_active) begin
                ctl_rvalid = 1'b1;
                ctl_raddr  = rsp_addr;
                ctl_rdata  = rd_beat(rsp_addr, rsp_beat);
                rsp_beat++;
                if (rsp_beat == BL) rsp_active = 1'b0;
            end
        end
    end

    // Monitor: compares downstream traffic and returned beats to the scoreboard.
    initial begin
        int unsigned wr_beat;
        int          id;
        down_t       e;
        rbeat_t      r;
        wr_beat = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_beat = 0;
                continue;
            end
            if (bmem_read && bmem_write) check("rw_exclusive", 64'd1, 64'd0);
            if (rq_ready == 2'b11) check("ready_onehot", 64'd1, 64'd0);
            if (rq_rvalid == 2'b11) check("rvalid_onehot", 64'd1, 64'd0);
            if (bmem_ready && (bmem_read || bmem_write)) begin
                id = rq_ready[1] ? 1 : 0;
                check("ready_pass", 64'(|rq_ready), 64'd1);
                if (bmem_read || wr_beat == 0) begin
                    if (exp_gnt.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
                    else check("gnt_order", 64'(id), 64'(exp_gnt.pop_front()));
                    start_cyc[id] = cyc;
                end
                if (exp_down[id].size() == 0) begin
                    check("down_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_down[id].pop_front();
                    check("down_kind", 64'(bmem_write), 64'(e.wr));
                    check("down_addr", 64'(bmem_addr), 64'(e.addr));
                    if (bmem_write) check("down_wdata", bmem_wdata, e.data);
                end
                if (bmem_read) rsp_q.push_back(bmem_addr);
                if (bmem_write) wr_beat = (wr_beat == BL - 1) ? 0 : wr_beat + 1;
            end
            for (int i = 0; i < 2; i++) begin
                if (rq_rvalid[i]) begin
                    if (exp_rd[i].size() == 0) begin
                        check("rvalid_unexpected", 64'd1, 64'd0);
                    end else begin
                        r = exp_rd[i].pop_front();
                        check("rv_data", rq_rdata[i], r.data);
                        check("rv_addr", 64'(rq_raddr[i]), 64'(r.addr));
                    end
                    last_rv_cyc[i] = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rq_read = '0; rq_write = '0; rq_addr = '0; rq_wdata = '0;
        stray_rv = 1'b0; stray_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // tie right after reset: ooo first, then ppl
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        fork
            req_read(0, 32'h1000_0000);
            req_read(1, 32'h1100_0000);
        join_none
        wait_drain("pair1");

        exp_gnt.push_back(0); exp_gnt.push_back(1);
        fork
            req_read(0, 32'h1000_0040);
            req_read(1, 32'h1100_0040);
        join_none
        wait_drain("pair2");

        // single read: forwarded one cycle after the request
        exp_gnt.push_back(0);
        fork
            req_read(0, 32'h1000_0000);
        join_none
        @(negedge clk);
        check("rd_lat_idle", 64'(bmem_read), 64'd0);
        @(negedge clk);
        check("rd_lat_fwd", 64'(bmem_read), 64'd1);
        check("rd_lat_addr", 64'(bmem_addr), 64'h1000_0000);
        wait_drain("single_rd");

        // tie after an ooo grant: ppl wins
        exp_gnt.push_back(1); exp_gnt.push_back(0);
        fork
            req_read(0, 32'h1000_0080);
            req_read(1, 32'h1100_0080);
        join_none
        wait_drain("pair3");

        // write burst under back-pressure; leading pattern entry covers the IDLE cycle
        foreach (rdy_pat[i]) rdy_pat.delete();
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        exp_gnt.push_back(1);
        fork
            req_write(1, 32'h2000_0040, 64'h0000_0000_0000_00D0);
        join_none
        repeat (7) @(negedge clk);
        check("wr_last_beat", 64'(bmem_write && bmem_ready), 64'd1);
        @(negedge clk);
        check("wr_idle_after", 64'(bmem_write), 64'd0);
        wait_drain("wr_bp");

        // ppl write arriving during an ooo read waits for the last beat
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        fork
            req_read(0, 32'h1000_0100);
        join_none
        repeat (2) @(posedge clk);
        #1;
        fork
            req_write(1, 32'h2000_0080, 64'h0000_0000_0000_00E0);
        join_none
        wait_drain("b2b");
        check("b2b_gap", 64'(start_cyc[1] - last_rv_cyc[0]), 64'd2);

        stray_rv = 1'b1; stray_rdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        check("stray_ooo_rvalid", 64'(rq_rvalid[0]), 64'd0);
        check("stray_ppl_rvalid", 64'(rq_rvalid[1]), 64'd0);
        @(posedge clk); #1;
        stray_rv = 1'b0;
        @(posedge clk); #1;

        // reset after two of four ooo write beats
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
        for (int i = 0; i < 5; i++) rdy_pat.push_back(1'b0);
        exp_gnt.push_back(0);
        fork
            req_write(0, 32'h3000_0080, 64'h0000_0000_0000_00F0);
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_beats_taken", 64'(exp_down[0].size()), 64'd2);
        rst = 1'b1; abort = 1'b1;
        rq_read = '0; rq_write = '0;
        exp_down[0].delete(); exp_down[1].delete();
        exp_gnt.delete(); rsp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        rdy_pat.delete();
        @(posedge clk); #1;

        // last_gnt is back to ppl, so ooo wins the tie
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        fork
            req_read(0, 32'h1000_0200);
            req_read(1, 32'h1100_0200);
        join_none
        wait_drain("pair_after_rst");

        check("final_queues_empty",
              64'(exp_down[0].size() + exp_down[1].size() + exp_rd[0].size() +
                  exp_rd[1].size() + exp_gnt.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
